// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and decode helpers for the load/store unit.
// Holds FSM state, access size and the load/store funct3 encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_ACCESS2 = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_load_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } funct3_store_t;

    function automatic logic f3_legal(
        input logic       st,
        input logic [2:0] f3
    );
        logic ok;
        if (st) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) ||
                 (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB)  || (f3 == F3_LH) ||
                 (f3 == F3_LW)  || (f3 == F3_LBU) ||
                 (f3 == F3_LHU);
        end
        return ok;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] sz,
        input logic [1:0] off
    );
        return ((sz == SZ_HALF) && off[0]) ||
               ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
// Ports: size_i/off_i/unsigned_i select the access shape; wdata_i,
// rdata_lo_i, rdata_hi_i are raw data; be_lo_o/be_hi_o are enables for
// the first and second word; wdata_o is lane-shifted store data;
// rdata_o is extended load data; misaligned_o flags unnatural alignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_lo_i,
    input  logic [31:0] rdata_hi_i,
    output logic [3:0]  be_lo_o,
    output logic [3:0]  be_hi_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [7:0]  mask;
    logic [7:0]  be8;
    logic [5:0]  sh;
    logic [31:0] rot;
    logic [31:0] win;

    always_comb begin
        mask = 8'h00;
        unique case (size_i)
            SZ_BYTE: mask = 8'h01;
            SZ_HALF: mask = 8'h03;
            SZ_WORD: mask = 8'h0F;
            default: mask = 8'h00;
        endcase
        // Enables over an 8-byte window; the upper nibble is
        // only non-zero for accesses crossing into the next word.
        be8     = mask << off_i;
        be_lo_o = be8[3:0];
        be_hi_o = be8[7:4];

        sh  = {1'b0, off_i, 3'b000};
        rot = (wdata_i << sh) | (wdata_i >> (6'd32 - sh));
        win = (rdata_lo_i >> sh) | (rdata_hi_i << (6'd32 - sh));

        misaligned_o = misaligned(size_i, off_i);

        // Rotation places each byte in its lane for split accesses;
        // naturally aligned ones use the replicated form.
        if (misaligned_o) begin
            wdata_o = rot;
        end else begin
            unique case (size_i)
                SZ_BYTE: wdata_o = {4{wdata_i[7:0]}};
                SZ_HALF: wdata_o = {2{wdata_i[15:0]}};
                default: wdata_o = wdata_i;
            endcase
        end

        unique case (size_i)
            SZ_BYTE: rdata_o = unsigned_i ?
                {24'b0, win[7:0]} :
                {{24{win[7]}}, win[7:0]};
            SZ_HALF: rdata_o = unsigned_i ?
                {16'b0, win[15:0]} :
                {{16{win[15]}}, win[15:0]};
            default: rdata_o = win;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and writeback; issues word-aligned
// memory accesses with byte enables and returns extended load data.
// Ports: clk_i, reset_n_i; req_* from execute (valid/ready); mem_* to data
// memory (valid/ready, rdata same cycle); resp_* to writeback (valid/ready).
// Macro LSU_MISALIGNED_SPLIT_EN: split word-crossing accesses in two.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_is_store_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [31:0]           resp_rdata_o,
    output logic [4:0]            resp_rd_o,
    output logic                  resp_err_o
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_t            state_q, state_d;
    logic                  st_q, st_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [4:0]            rd_q, rd_d;
    logic [31:0]           rlo_q, rlo_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [3:0]            al_be_lo;
    logic [3:0]            al_be_hi;
    logic [31:0]           al_wdata;
    logic [31:0]           al_rdata;
    logic                  al_mis;
    logic [31:0]           rlo_sel;
    logic [31:0]           ext;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  new_err;

    // Second beat merges the held low word with the live high word.
    assign rlo_sel = (state_q == ST_ACCESS2) ? rlo_q : mem_rdata_i;
    assign ext     = st_q ? 32'b0 : al_rdata;
    assign waddr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    lsu_align u_align (
        .size_i      (f3_q[1:0]),
        .off_i       (addr_q[1:0]),
        .unsigned_i  (f3_q[2]),
        .wdata_i     (wdata_q),
        .rdata_lo_i  (rlo_sel),
        .rdata_hi_i  (mem_rdata_i),
        .be_lo_o     (al_be_lo),
        .be_hi_o     (al_be_hi),
        .wdata_o     (al_wdata),
        .rdata_o     (al_rdata),
        .misaligned_o(al_mis)
    );

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rlo_d   = rlo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        new_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    new_err = !f3_legal(req_is_store_i, req_funct3_i) ||
                              (!SPLIT_EN &&
                               misaligned(req_funct3_i[1:0],
                                          req_addr_i[1:0]));
                    st_d    = req_is_store_i;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rd_d    = req_is_store_i ? 5'd0 : req_rd_i;
                    rdata_d = 32'b0;
                    err_d   = new_err;
                    state_d = new_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ready_i) begin
                    if (SPLIT_EN && al_mis && (al_be_hi != 4'b0)) begin
                        rlo_d   = mem_rdata_i;
                        state_d = ST_ACCESS2;
                    end else begin
                        rdata_d = ext;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS2: begin
                if (mem_ready_i) begin
                    rdata_d = ext;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            st_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            rd_q    <= 5'b0;
            rlo_q   <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rlo_q   <= rlo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        mem_valid_o  = (state_q == ST_ACCESS) ||
                       (state_q == ST_ACCESS2);
        mem_we_o     = mem_valid_o && st_q;
        mem_addr_o   = '0;
        mem_be_o     = 4'b0;
        if (state_q == ST_ACCESS) begin
            mem_addr_o = waddr;
            mem_be_o   = al_be_lo;
        end else if (state_q == ST_ACCESS2) begin
            mem_addr_o = waddr + ADDR_WIDTH'(4);
            mem_be_o   = al_be_hi;
        end
        mem_wdata_o  = mem_we_o ? al_wdata : 32'b0;
        resp_valid_o = (state_q == ST_RESP);
        resp_rdata_o = rdata_q;
        resp_rd_o    = rd_q;
        resp_err_o   = err_q;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit. Sits between the execute stage (which delivers the ALU_OP_ADD effective address) and the writeback stage (REGFILE_IN_SEL path).
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned data-memory transactions with byte enables. Sign- or zero-extends load data.
- Runs the request, memory and response handshakes through a small FSM.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr_i and mem_addr_o.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  execute stage presents a request
- req_ready_o  out  1  LSU can accept a request (high only in IDLE)
- req_is_store_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  funct3_load_t / funct3_store_t encoding
- req_addr_i  in  ADDR_WIDTH  effective byte address
- req_wdata_i  in  32  store data (rs2), right-aligned
- req_rd_i  in  5  load destination register
- mem_valid_o  out  1  memory transaction valid
- mem_ready_i  in  1  memory accepts the transaction; read data valid in the same cycle
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_WIDTH  word address, bits [1:0] always 0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-shifted store data
- mem_rdata_i  in  32  read data
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  writeback accepts the response
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_rd_o  out  5  destination register; 0 for stores
- resp_err_o  out  1  misaligned or illegal funct3

Behaviour:
- Reset (async, reset_n_i low):
  - FSM goes to IDLE.
  - mem_valid_o, resp_valid_o, resp_err_o, mem_we_o = 0; mem_be_o = 0; all data/address registers = 0.
  - Takes effect mid-transaction: mem_valid_o drops immediately; the aborted access is lost.
- FSM states: IDLE, ACCESS, RESP (plus ACCESS2 under the optional feature).
  - IDLE: req_ready_o = 1. On req_valid_i & req_ready_o, latch all req_* fields, then:
    - illegal or misaligned -> RESP with err = 1;
    - otherwise -> ACCESS.
  - ACCESS: mem_valid_o = 1, with mem_addr_o/we/be/wdata held stable until mem_ready_i. On mem_ready_i, capture the extended read data -> RESP.
  - RESP: resp_valid_o = 1, outputs held stable until resp_ready_i -> IDLE. No new request is accepted in the same cycle (req_ready_o = 0 outside IDLE).
- Latency, accept at cycle T:
  - mem_valid_o rises at T+1.
  - resp_valid_o rises the cycle after mem_ready_i; minimum T+2.
  - Error response at T+1 with no memory transaction.
- Legal funct3: load 000/001/010/100/101; store 000/001/010. Anything else is illegal.
- Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- Byte enables and store data:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111; wdata unchanged.
- Loads: mem_be_o uses the same enables.
  - Select the byte/half lane by addr[1:0].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Stores complete with a response: rdata = 0, rd = 0, err = 0.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Without it: misaligned accesses return resp_err_o = 1 as above.
- With it: misaligned half/word accesses crossing a word boundary do not error. They are split into two transactions:
  - ACCESS on word addr & ~3 with the low-part enables.
  - ACCESS2 on (addr & ~3) + 4 with the remaining enables.
  - Load bytes from both words are merged before extension.
  - A halfword at addr[1:0] = 01 does not cross a word boundary and is handled in a single ACCESS with be = 0110.
  - Illegal funct3 still errors.

Decomposition:
- Shared package gets:
  - lsu_state_t enum (IDLE/ACCESS/ACCESS2/RESP);
  - mem_size_t (BYTE/HALF/WORD) decoded from funct3[1:0];
  - the existing funct3_load_t / funct3_store_t.
- One natural sub-module: lsu_align. Purely combinational, mapping {size, addr[1:0], wdata/rdata, unsigned} to {be, shifted wdata, extended rdata, misaligned}.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, mem_ready_i high at T+1 -> mem_addr 0x100, be 1111, resp_rdata 0xDEADBEEF at T+2.
- LB addr 0x103, rdata 0x80FFFFFF -> be 1000, resp 0xFFFFFF80; repeat as LBU -> resp 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD -> mem_we 1, be 1100, mem_wdata 0xABCDABCD, resp_rd 0.
- LW addr 0x101 -> no mem_valid_o; resp_err 1 at T+1. With LSU_MISALIGNED_SPLIT_EN: two accesses to 0x100/0x104 with be 1110/0001; words 0x44332211 and 0x88776655 give resp 0x55443322.
- Backpressure: mem_ready_i low for 3 cycles, then resp_ready_i low for 2 cycles -> mem_* and resp_* stable throughout, req_ready_o 0 until the response is consumed.
- reset_n_i asserted while in ACCESS -> mem_valid_o 0 immediately; after release, FSM in IDLE, req_ready_o 1, no response emitted; funct3 011 load -> resp_err 1.
